// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg: shared widths and FSM encoding for the copy engine
package mem_copy_engine_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mem_copy_engine_addr_gen.sv
// copy_addr_gen: source/destination pointers, copy direction and remaining-word count
module copy_addr_gen import mem_copy_engine_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  output logic [ADDR_W-1:0] src_nxt_o,
  output logic [ADDR_W-1:0] dst_ptr_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_a;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              desc_q, desc_d, ovl;
  // A destination starting inside the source block would clobber unread words, so copy top-down
  always_comb begin
    len_a  = ADDR_W'(length_i);
    ovl    = (dst_addr_i > src_addr_i) && (dst_addr_i < src_addr_i + len_a);
    desc_d = load_i ? ovl : desc_q;
    src_d  = load_i ? (ovl ? src_addr_i + len_a - ADDR_W'(1) : src_addr_i) :
             step_i ? (desc_q ? src_q - ADDR_W'(1) : src_q + ADDR_W'(1)) : src_q;
    dst_d  = load_i ? (ovl ? dst_addr_i + len_a - ADDR_W'(1) : dst_addr_i) :
             step_i ? (desc_q ? dst_q - ADDR_W'(1) : dst_q + ADDR_W'(1)) : dst_q;
    rem_d  = load_i ? length_i : step_i ? rem_q - LEN_W'(1) : rem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      desc_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      rem_q  <= rem_d;
      desc_q <= desc_d;
    end
  end
  assign src_nxt_o = src_d;
  assign dst_ptr_o = dst_q;
  assign last_o    = rem_q == LEN_W'(1);
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: memory-port initiator copying a word block with a running checksum
module mem_copy_engine import mem_copy_engine_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [LEN_W-1:0]  words_copied
);
  state_e            state_q, state_d;
  logic              load, step, last, accept;
  logic [ADDR_W-1:0] src_nxt, dst_ptr, address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, checksum_q, checksum_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              busy_q, busy_d, done_q, done_d;
  assign accept = state_q == IDLE && start;
  assign load   = accept && length != '0;
  assign step   = state_q == WRITE;
  copy_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .src_addr_i(src_addr),
    .dst_addr_i(dst_addr),
    .length_i  (length),
    .src_nxt_o (src_nxt),
    .dst_ptr_o (dst_ptr),
    .last_o    (last)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (accept ? (length == '0 ? DONE : READ) : IDLE) :
              state_q == READ  ? WRITE :
              state_q == WRITE ? (last ? DONE : READ) : IDLE;
  end
  // Outputs are registered, so they are derived from the state being entered
  always_comb begin
    mem_read_d  = state_d == READ;
    mem_write_d = state_d == WRITE;
    busy_d      = state_d == READ || state_d == WRITE;
    done_d      = state_d == DONE;
    address_d   = state_d == READ ? src_nxt : state_d == WRITE ? dst_ptr : address_q;
    wdata_d     = state_q == READ ? rdata : wdata_q;
    checksum_d  = accept ? '0 : state_q == READ ? checksum_q + rdata : checksum_q;
    words_d     = accept ? '0 : step ? words_q + LEN_W'(1) : words_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      checksum_q  <= '0;
      words_q     <= '0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      checksum_q  <= checksum_d;
      words_q     <= words_d;
    end
  end
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign address      = address_q;
  assign wdata        = wdata_q;
  assign checksum     = checksum_q;
  assign words_copied = words_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed scenarios against a 64K-word behavioural memory
module tb_mem_copy_engine;
  logic        clk = 1'b0, rst, start;
  logic [31:0] src_addr, dst_addr, rdata, address, wdata, checksum;
  logic [15:0] length, words_copied;
  logic        MemRead, MemWrite, busy, done;
  logic        poke_en;
  logic [31:0] poke_a, poke_d;
  logic [31:0] mem [0:65535];
  logic [31:0] wr_log [0:255];
  int wr_total = 0, acc_total = 0, hits3000 = 0, viol = 0;
  int vecs = 0, errs = 0;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .rdata(rdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .wdata(wdata), .busy(busy), .done(done),
    .checksum(checksum), .words_copied(words_copied)
  );

  always #5 clk = ~clk;
  assign rdata = MemRead ? mem[address[15:0]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_a[15:0]] <= poke_d;
    else if (MemWrite) begin
      mem[address[15:0]] <= wdata;
      wr_log[wr_total[7:0]] <= address;
      wr_total <= wr_total + 1;
    end
    if ((MemRead || MemWrite) && address[15:0] == 16'd3000) hits3000 <= hits3000 + 1;
    if (MemRead || MemWrite) acc_total <= acc_total + 1;
  end

  always @(negedge clk) begin
    assert (!(MemRead && MemWrite)) else $error("FAIL strobe_excl both strobes high at %0t", $time);
    if ((MemRead && MemWrite) || (MemWrite && !busy)) viol <= viol + 1;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk); src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          output int done_cyc, output int busy_cyc);
    done_cyc = 0; busy_cyc = 0;
    launch(s, d, n);
    for (int k = 1; k <= 2 * int'(n) + 8; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done && done_cyc == 0) done_cyc = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if ({MemRead, MemWrite, busy, done} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b exp 0000", {MemRead, MemWrite, busy, done}); end
    vecs++; if (address !== 32'h0) begin errs++; $display("FAIL reset_address got %0h exp 0", address); end
    vecs++; if (wdata !== 32'h0) begin errs++; $display("FAIL reset_wdata got %0h exp 0", wdata); end
    vecs++; if ({checksum, words_copied} !== 48'h0) begin errs++; $display("FAIL reset_counts got %0h/%0d exp 0/0", checksum, words_copied); end
    rst = 1'b0;
  endtask

  task automatic test_plain_copy();
    int dc, bc;
    for (int i = 0; i < 4; i++) begin poke(1000 + i, i + 1); poke(2000 + i, 32'h0); end
    run_copy(1000, 2000, 4, dc, bc);
    vecs++; if (dc !== 9) begin errs++; $display("FAIL plain_done_cycle got %0d exp 9", dc); end
    vecs++; if (bc !== 8) begin errs++; $display("FAIL plain_busy_cycles got %0d exp 8", bc); end
    vecs++; if (checksum !== 32'd10) begin errs++; $display("FAIL plain_checksum got %0d exp 10", checksum); end
    vecs++; if (words_copied !== 16'd4) begin errs++; $display("FAIL plain_words got %0d exp 4", words_copied); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (mem[2000 + i] !== i + 1) begin errs++; $display("FAIL plain_dst[%0d] got %0d exp %0d", i, mem[2000 + i], i + 1); end
    end
  endtask

  task automatic test_overlap();
    int dc, bc, w0;
    for (int i = 0; i < 5; i++) poke(1000 + i, 10 * (i + 1));
    w0 = wr_total;
    run_copy(1000, 1002, 5, dc, bc);
    vecs++; if (wr_log[w0[7:0]] !== 32'd1006) begin errs++; $display("FAIL overlap_first_write got %0d exp 1006", wr_log[w0[7:0]]); end
    vecs++; if (wr_log[8'(w0 + 4)] !== 32'd1002) begin errs++; $display("FAIL overlap_last_write got %0d exp 1002", wr_log[8'(w0 + 4)]); end
    vecs++; if (checksum !== 32'd150) begin errs++; $display("FAIL overlap_checksum got %0d exp 150", checksum); end
    vecs++; if (dc !== 11) begin errs++; $display("FAIL overlap_done_cycle got %0d exp 11", dc); end
    for (int i = 0; i < 5; i++) begin
      vecs++; if (mem[1002 + i] !== 10 * (i + 1)) begin errs++; $display("FAIL overlap_dst[%0d] got %0d exp %0d", i, mem[1002 + i], 10 * (i + 1)); end
    end
  endtask

  task automatic test_zero_len();
    int dc, bc, a0;
    a0 = acc_total;
    run_copy(1000, 2000, 0, dc, bc);
    vecs++; if (dc !== 1) begin errs++; $display("FAIL zero_done_cycle got %0d exp 1", dc); end
    vecs++; if (acc_total !== a0) begin errs++; $display("FAIL zero_accesses got %0d exp 0", acc_total - a0); end
    vecs++; if (bc !== 0) begin errs++; $display("FAIL zero_busy got %0d exp 0", bc); end
    vecs++; if ({checksum, words_copied} !== 48'h0) begin errs++; $display("FAIL zero_counts got %0h/%0d exp 0/0", checksum, words_copied); end
  endtask

  task automatic test_start_busy();
    int dc, h0;
    for (int i = 0; i < 4; i++) poke(1100 + i, 5 + i);
    h0 = hits3000; dc = 0;
    launch(1100, 2100, 4);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done && dc == 0) dc = k;
      if (k == 3) begin start = 1'b1; src_addr = 3000; dst_addr = 3100; length = 2; end
      if (k == 5) start = 1'b0;
    end
    vecs++; if (dc !== 9) begin errs++; $display("FAIL busy_done_cycle got %0d exp 9", dc); end
    vecs++; if (checksum !== 32'd26) begin errs++; $display("FAIL busy_checksum got %0d exp 26", checksum); end
    vecs++; if (hits3000 !== h0) begin errs++; $display("FAIL busy_addr3000 got %0d exp 0 accesses", hits3000 - h0); end
    vecs++; if (mem[2103] !== 32'd8) begin errs++; $display("FAIL busy_dst3 got %0d exp 8", mem[2103]); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int i = 0; i < 8; i++) begin poke(1200 + i, 100 + i); poke(2200 + i, 32'hDEAD); end
    launch(1200, 2200, 8);
    for (int k = 1; k <= 7; k++) begin @(negedge clk); if (done) seen++; end
    rst = 1'b1;
    @(negedge clk);
    vecs++; if ({MemRead, MemWrite, busy, done} !== 4'b0) begin errs++; $display("FAIL rstmid_flags got %b exp 0000", {MemRead, MemWrite, busy, done}); end
    vecs++; if ({address, wdata, checksum, words_copied} !== 112'h0) begin errs++; $display("FAIL rstmid_outputs got %0h %0h %0h %0d exp zeros", address, wdata, checksum, words_copied); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (done) seen++; end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL rstmid_done_pulse got %0d exp 0", seen); end
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (mem[2200 + i] !== (i < 3 ? 100 + i : 32'hDEAD)) begin
        errs++; $display("FAIL rstmid_dst[%0d] got %0h exp %0h", i, mem[2200 + i], i < 3 ? 100 + i : 32'hDEAD);
      end
    end
  endtask

  task automatic test_checksum_wrap();
    int dc, bc;
    poke(1300, 32'hFFFF_FFFF); poke(1301, 32'h2);
    run_copy(1300, 2400, 2, dc, bc);
    vecs++; if (checksum !== 32'h1) begin errs++; $display("FAIL wrap_checksum got %0h exp 1", checksum); end
    vecs++; if (dc !== 5) begin errs++; $display("FAIL wrap_done_cycle got %0d exp 5", dc); end
    vecs++; if (words_copied !== 16'd2) begin errs++; $display("FAIL wrap_words got %0d exp 2", words_copied); end
    vecs++; if (mem[2400] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_dst0 got %0h exp ffffffff", mem[2400]); end
    vecs++; if (viol !== 0) begin errs++; $display("FAIL strobe_rules got %0d violations exp 0", viol); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    src_addr = '0; dst_addr = '0; length = '0;
    test_reset();
    test_plain_copy();
    test_overlap();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_checksum_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
